// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: clock divider to a pixel strobe, sync pulses,
// data-enable, active-area coordinates and line/frame start markers.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_DE_BEG   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_DE_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_DE_BEG   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_DE_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_act;
    logic             v_act;
    logic             de_d;
    logic [9:0]       pix_x_d;
    logic [9:0]       pix_y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    // h_cnt/v_cnt hold the pixel to be presented on the next strobe, so the
    // first strobe after reset presents (0,0) with no pipeline offset.
    always_comb begin
        h_next  = h_cnt + 10'd1;
        v_next  = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
        h_act   = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
        v_act   = (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
        de_d    = h_act && v_act;
        pix_x_d = de_d ? (h_cnt - H_DE_BEG) : '0;
        pix_y_d = de_d ? (v_cnt - V_DE_BEG) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            hsync       <= !(h_cnt < H_SYNC_END);
            vsync       <= !(v_cnt < V_SYNC_END);
            de          <= de_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing for reset/horizontal
// checks, plus a small raster (19x12 pixels) for full-frame checks at CLK_DIV=2 and 1.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic d_pe, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic s_pe, s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic f_pe, f_hs, f_vs, f_de, f_ls, f_fs;
    logic [9:0] f_x, f_y;

    logic [25:0] d_all, s_all, f_all;
    assign d_all = {d_pe, d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs};
    assign s_all = {s_pe, s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs};
    assign f_all = {f_pe, f_hs, f_vs, f_de, f_x, f_y, f_ls, f_fs};

    localparam logic [25:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(d_pe), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .pix_x(d_x), .pix_y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2)
    ) u_sml (
        .clk(clk), .rst(rst), .pix_en(s_pe), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .pix_x(s_x), .pix_y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2)
    ) u_fast (
        .clk(clk), .rst(rst), .pix_en(f_pe), .hsync(f_hs), .vsync(f_vs), .de(f_de),
        .pix_x(f_x), .pix_y(f_y), .line_start(f_ls), .frame_start(f_fs)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Align to the first sample of a small-raster frame (s_fs rising).
    task automatic wait_s_frame(output int waited);
        waited = 0;
        while (s_fs === 1'b1 && waited < 1000) begin tick(); waited++; end
        while (s_fs !== 1'b1 && waited < 1000) begin tick(); waited++; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (d_pe !== 1'b0) begin n_bad++; $display("FAIL rst_pe_edge1_div2: got %b want 0", d_pe); end
        n_cmp++; if (f_pe !== 1'b1) begin n_bad++; $display("FAIL rst_pe_edge1_div1: got %b want 1", f_pe); end
        tick();
        n_cmp++; if ({d_pe, d_hs, d_ls} !== 3'b110) begin n_bad++; $display("FAIL rst_edge2_div2 {pe,hs,ls}: got %b want 110", {d_pe, d_hs, d_ls}); end
        n_cmp++; if ({f_hs, f_vs, f_de, f_ls, f_fs} !== 5'b00011) begin n_bad++; $display("FAIL rst_edge2_div1 {hs,vs,de,ls,fs}: got %b want 00011", {f_hs, f_vs, f_de, f_ls, f_fs}); end
        tick();
        n_cmp++; if ({d_pe, d_hs, d_vs, d_de, d_ls, d_fs} !== 6'b000011) begin n_bad++; $display("FAIL rst_first_pixel_def: got %b want 000011", {d_pe, d_hs, d_vs, d_de, d_ls, d_fs}); end
        n_cmp++; if ({s_pe, s_hs, s_vs, s_de, s_ls, s_fs} !== 6'b000011) begin n_bad++; $display("FAIL rst_first_pixel_sml: got %b want 000011", {s_pe, s_hs, s_vs, s_de, s_ls, s_fs}); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (d_all !== RST_VEC) begin n_bad++; $display("FAIL rst_async_def: got %h want %h", d_all, RST_VEC); end
        n_cmp++; if (s_all !== RST_VEC) begin n_bad++; $display("FAIL rst_async_sml: got %h want %h", s_all, RST_VEC); end
        n_cmp++; if (f_all !== RST_VEC) begin n_bad++; $display("FAIL rst_async_fast: got %h want %h", f_all, RST_VEC); end
        tick();
        n_cmp++; if (f_all !== RST_VEC) begin n_bad++; $display("FAIL rst_held_fast: got %h want %h", f_all, RST_VEC); end
    endtask

    task automatic test_horizontal();
        int cyc = 0;
        int hs_low = 0;
        int pe_cnt = 0;
        int ls_cnt = 0;
        rst = 1'b0;
        while (d_ls !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL h_first_line_latency: got %0d clks want 3", cyc); end
        for (int i = 0; i < 1600; i++) begin
            if (d_hs === 1'b0) hs_low++;
            if (d_pe === 1'b1) pe_cnt++;
            if (d_ls === 1'b1) ls_cnt++;
            tick();
        end
        n_cmp++; if (hs_low != 192) begin n_bad++; $display("FAIL h_hsync_low_clks: got %0d want 192", hs_low); end
        n_cmp++; if (pe_cnt != 800) begin n_bad++; $display("FAIL h_pix_en_per_line: got %0d want 800", pe_cnt); end
        n_cmp++; if (ls_cnt != 2) begin n_bad++; $display("FAIL h_line_start_clks: got %0d want 2", ls_cnt); end
        n_cmp++; if ({d_ls, d_fs, d_hs, d_vs} !== 4'b1000) begin n_bad++; $display("FAIL h_second_line_start {ls,fs,hs,vs}: got %b want 1000", {d_ls, d_fs, d_hs, d_vs}); end
    endtask

    task automatic test_active_window();
        int waited;
        int de_cnt = 0, first_de = -1, last_de = -1, bad_zero = 0;
        int hs_low = 0, vs_low = 0, ls_cnt = 0, fs_cnt = 0;
        logic [9:0] fx = '0, fy = '0, lx = '0, ly = '0;
        logic [4:0] w227 = '0, w228 = '0;
        wait_s_frame(waited);
        n_cmp++; if (s_fs !== 1'b1) begin n_bad++; $display("FAIL aw_frame_timeout: got fs=%b after %0d clks want 1", s_fs, waited); end
        for (int p = 0; p <= 228; p++) begin
            if (s_de === 1'b1) begin
                de_cnt++;
                if (first_de < 0) begin first_de = p; fx = s_x; fy = s_y; end
                last_de = p; lx = s_x; ly = s_y;
            end else if (s_x !== 10'd0 || s_y !== 10'd0) begin
                bad_zero++;
            end
            if (p < 228) begin
                if (s_hs === 1'b0) hs_low++;
                if (s_vs === 1'b0) vs_low++;
                if (s_ls === 1'b1) ls_cnt++;
                if (s_fs === 1'b1) fs_cnt++;
            end
            if (p == 227) w227 = {s_hs, s_vs, s_de, s_ls, s_fs};
            if (p == 228) w228 = {s_hs, s_vs, s_de, s_ls, s_fs};
            if (p < 228) begin tick(); tick(); end
        end
        n_cmp++; if (de_cnt != 50) begin n_bad++; $display("FAIL aw_de_count: got %0d want 50", de_cnt); end
        n_cmp++; if (first_de != 102) begin n_bad++; $display("FAIL aw_first_de_index: got %0d want 102", first_de); end
        n_cmp++; if ({fx, fy} !== {10'd0, 10'd0}) begin n_bad++; $display("FAIL aw_first_xy: got %0d,%0d want 0,0", fx, fy); end
        n_cmp++; if (last_de != 187) begin n_bad++; $display("FAIL aw_last_de_index: got %0d want 187", last_de); end
        n_cmp++; if ({lx, ly} !== {10'd9, 10'd4}) begin n_bad++; $display("FAIL aw_last_xy: got %0d,%0d want 9,4", lx, ly); end
        n_cmp++; if (bad_zero != 0) begin n_bad++; $display("FAIL aw_xy_zero_outside: got %0d nonzero want 0", bad_zero); end
        n_cmp++; if (hs_low != 48) begin n_bad++; $display("FAIL aw_hsync_low_pixels: got %0d want 48", hs_low); end
        n_cmp++; if (vs_low != 38) begin n_bad++; $display("FAIL aw_vsync_low_pixels: got %0d want 38", vs_low); end
        n_cmp++; if (ls_cnt != 12) begin n_bad++; $display("FAIL aw_lines_per_frame: got %0d want 12", ls_cnt); end
        n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL aw_frame_starts: got %0d want 1", fs_cnt); end
        n_cmp++; if (w227 !== 5'b11000) begin n_bad++; $display("FAIL wrap_last_pixel {hs,vs,de,ls,fs}: got %b want 11000", w227); end
        n_cmp++; if (w228 !== 5'b00011) begin n_bad++; $display("FAIL wrap_next_frame {hs,vs,de,ls,fs}: got %b want 00011", w228); end
    endtask

    task automatic test_reset_mid_frame();
        int waited;
        wait_s_frame(waited);
        n_cmp++; if (s_fs !== 1'b1) begin n_bad++; $display("FAIL mid_frame_timeout: got fs=%b want 1", s_fs); end
        repeat (286) tick();
        n_cmp++; if ({s_de, s_x, s_y} !== {1'b1, 10'd3, 10'd2}) begin n_bad++; $display("FAIL mid_pixel_143 {de,x,y}: got %b,%0d,%0d want 1,3,2", s_de, s_x, s_y); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (s_all !== RST_VEC) begin n_bad++; $display("FAIL mid_async_reset: got %h want %h", s_all, RST_VEC); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++; if ({s_pe, s_hs, s_vs, s_de, s_ls, s_fs} !== 6'b000011) begin n_bad++; $display("FAIL mid_restart_origin: got %b want 000011", {s_pe, s_hs, s_vs, s_de, s_ls, s_fs}); end
        repeat (2) tick();
        n_cmp++; if ({s_ls, s_fs, s_hs} !== 3'b000) begin n_bad++; $display("FAIL mid_restart_h1 {ls,fs,hs}: got %b want 000", {s_ls, s_fs, s_hs}); end
    endtask

    task automatic test_clk_div1();
        int waited = 0;
        int pe_cnt = 0, ls_cnt = 0, de_cnt = 0, fs_cnt = 0;
        while (f_fs === 1'b1 && waited < 1000) begin tick(); waited++; end
        while (f_fs !== 1'b1 && waited < 1000) begin tick(); waited++; end
        n_cmp++; if (f_fs !== 1'b1) begin n_bad++; $display("FAIL div1_frame_timeout: got fs=%b want 1", f_fs); end
        for (int i = 0; i < 228; i++) begin
            if (f_pe === 1'b1) pe_cnt++;
            if (f_ls === 1'b1) ls_cnt++;
            if (f_de === 1'b1) de_cnt++;
            if (f_fs === 1'b1) fs_cnt++;
            tick();
        end
        n_cmp++; if (pe_cnt != 228) begin n_bad++; $display("FAIL div1_pix_en_const: got %0d want 228", pe_cnt); end
        n_cmp++; if (ls_cnt != 12) begin n_bad++; $display("FAIL div1_line_start_clks: got %0d want 12", ls_cnt); end
        n_cmp++; if (de_cnt != 50) begin n_bad++; $display("FAIL div1_de_count: got %0d want 50", de_cnt); end
        n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL div1_frame_start_clks: got %0d want 1", fs_cnt); end
        n_cmp++; if ({f_fs, f_ls} !== 2'b11) begin n_bad++; $display("FAIL div1_frame_period {fs,ls}: got %b want 11", {f_fs, f_ls}); end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        test_reset();
        test_horizontal();
        test_active_window();
        test_reset_mid_frame();
        test_clk_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
